// File: rtl/led_source_arbiter_if.sv
// rtl/led_source_arbiter_if.sv - request/pattern bundle and LED bank outputs of the arbiter
interface led_source_arbiter_if;
  logic [3:0]  req_i;
  logic [63:0] pattern_i;
  logic [15:0] led_out;
  logic [3:0]  grant_o;
  logic        active_o;
  logic [15:0] switch_count_o;

  modport master (
    output req_i, pattern_i,
    input  led_out, grant_o, active_o, switch_count_o
  );

  modport slave (
    input  req_i, pattern_i,
    output led_out, grant_o, active_o, switch_count_o
  );
endinterface

// File: rtl/led_source_arbiter.sv
// rtl/led_source_arbiter.sv - fixed-priority LED bank arbiter with minimum-hold timer
// Four requesters share the 16-bit LED bank; a grant is held for HOLD_CYCLES before voluntary release.
module led_source_arbiter #(
  parameter int          HOLD_CYCLES  = 2000000,
  parameter bit          PREEMPT      = 1'b1,
  parameter logic [15:0] IDLE_PATTERN = 16'h0000
) (
  input  logic             clock,
  input  logic             reset_n,
  led_source_arbiter_if.slave bus
);

  localparam int TW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [TW-1:0] RELOAD = TW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    OWN  = 2'd2
  } state_t;

  state_t        state, state_n;
  logic [1:0]    owner, owner_n;
  logic [3:0]    grant, grant_n;
  logic [15:0]   led, led_n;
  logic          active, active_n;
  logic [TW-1:0] timer, timer_n;
  logic [15:0]   count, count_n;

  logic [1:0]    top;
  logic          any_req;

  // Highest asserted request wins; later iterations overwrite lower indices.
  always_comb begin
    top = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (bus.req_i[i]) top = 2'(i);
    end
    any_req = |bus.req_i;
  end

  always_comb begin
    state_n = state;
    owner_n = owner;
    grant_n = grant;
    timer_n = (timer != '0) ? timer - TW'(1) : '0;

    case (state)
      IDLE: begin
        if (any_req) begin
          state_n = HOLD;
          owner_n = top;
          grant_n = 4'b0001 << top;
          timer_n = RELOAD;
        end
      end
      HOLD: begin
        // Preemption wins over expiry landing in the same cycle.
        if (PREEMPT && any_req && (top > owner)) begin
          owner_n = top;
          grant_n = 4'b0001 << top;
          timer_n = RELOAD;
        end else if (timer == '0) begin
          state_n = OWN;
        end
      end
      OWN: begin
        if (!any_req) begin
          state_n = IDLE;
          grant_n = 4'b0000;
        end else if (top != owner) begin
          state_n = HOLD;
          owner_n = top;
          grant_n = 4'b0001 << top;
          timer_n = RELOAD;
        end
      end
      default: begin
        state_n = IDLE;
        grant_n = 4'b0000;
        timer_n = '0;
      end
    endcase

    led_n    = (state_n == IDLE) ? IDLE_PATTERN : bus.pattern_i[{owner_n, 4'b0000} +: 16];
    active_n = |grant_n;
    count_n  = ((grant_n != grant) && (count != 16'hFFFF)) ? count + 16'd1 : count;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      owner  <= 2'd0;
      grant  <= 4'b0000;
      led    <= IDLE_PATTERN;
      active <= 1'b0;
      timer  <= '0;
      count  <= 16'd0;
    end else begin
      state  <= state_n;
      owner  <= owner_n;
      grant  <= grant_n;
      led    <= led_n;
      active <= active_n;
      timer  <= timer_n;
      count  <= count_n;
    end
  end

  assign bus.led_out        = led;
  assign bus.grant_o        = grant;
  assign bus.active_o       = active;
  assign bus.switch_count_o = count;

endmodule

// File: tb/tb_led_source_arbiter.sv
// tb/tb_led_source_arbiter.sv - self-checking bench for led_source_arbiter
// Instance a: HOLD=8 PREEMPT=1, b: HOLD=8 PREEMPT=0, c: HOLD=1 PREEMPT=1, all sharing one stimulus.
`timescale 1ns/1ps
module tb_led_source_arbiter;

  logic        clock;
  logic        reset_n;
  logic [3:0]  req;
  logic [63:0] pat;

  int vectors;
  int miscompares;

  led_source_arbiter_if ia();
  led_source_arbiter_if ib();
  led_source_arbiter_if ic();

  assign ia.req_i = req;
  assign ib.req_i = req;
  assign ic.req_i = req;
  assign ia.pattern_i = pat;
  assign ib.pattern_i = pat;
  assign ic.pattern_i = pat;

  led_source_arbiter #(.HOLD_CYCLES(8), .PREEMPT(1'b1), .IDLE_PATTERN(16'h0000)) dut_a (
    .clock(clock), .reset_n(reset_n), .bus(ia.slave));
  led_source_arbiter #(.HOLD_CYCLES(8), .PREEMPT(1'b0), .IDLE_PATTERN(16'h0000)) dut_b (
    .clock(clock), .reset_n(reset_n), .bus(ib.slave));
  led_source_arbiter #(.HOLD_CYCLES(1), .PREEMPT(1'b1), .IDLE_PATTERN(16'h0000)) dut_c (
    .clock(clock), .reset_n(reset_n), .bus(ic.slave));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: owner index (-1 = nobody) and age = cycles the current grant has been shown.
  int          m_owner [3];
  int          m_age   [3];
  logic [15:0] m_cnt   [3];
  logic [3:0]  m_grant [3];
  logic [15:0] m_led   [3];

  function automatic int hold_of(input int k);
    return (k == 2) ? 1 : 8;
  endfunction

  function automatic bit preempt_of(input int k);
    return (k != 1);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_owner[k] = -1;
      m_age[k]   = 0;
      m_cnt[k]   = 16'h0000;
      m_grant[k] = 4'b0000;
      m_led[k]   = 16'h0000;
    end
  endtask

  task automatic model_update(input logic [3:0] r, input logic [63:0] p);
    int top;
    int prev;
    top = -1;
    for (int b = 0; b < 4; b++) if (r[b]) top = b;
    for (int k = 0; k < 3; k++) begin
      prev = m_owner[k];
      if (m_owner[k] < 0) begin
        if (top >= 0) begin m_owner[k] = top; m_age[k] = 1; end
      end else if (m_age[k] <= hold_of(k)) begin
        if (preempt_of(k) && top > m_owner[k]) begin m_owner[k] = top; m_age[k] = 1; end
        else m_age[k] = m_age[k] + 1;
      end else begin
        if (top < 0) m_owner[k] = -1;
        else if (top != m_owner[k]) begin m_owner[k] = top; m_age[k] = 1; end
      end
      if (m_owner[k] != prev && m_cnt[k] != 16'hFFFF) m_cnt[k] = m_cnt[k] + 16'd1;
      m_grant[k] = (m_owner[k] < 0) ? 4'b0000 : (4'b0001 << m_owner[k]);
      m_led[k]   = (m_owner[k] < 0) ? 16'h0000 : p[m_owner[k]*16 +: 16];
    end
  endtask

  // One clock: model follows the inputs seen at the rising edge; returns on the falling edge.
  task automatic tick();
    @(posedge clock);
    if (!reset_n) model_reset();
    else model_update(req, pat);
    @(negedge clock);
  endtask

  task automatic drain();
    req = 4'b0000;
    for (int i = 0; i < 12; i++) tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    req = 4'b0000;
    pat = 64'h0;
    model_reset();
    tick(); tick(); tick();
    vectors++;
    if ({ia.grant_o, ia.led_out, ia.active_o, ia.switch_count_o} !== {4'b0, 16'h0, 1'b0, 16'h0}) begin
      miscompares++;
      $display("FAIL reset_hold: grant=%h led=%h active=%b count=%h expected all zero",
               ia.grant_o, ia.led_out, ia.active_o, ia.switch_count_o);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      vectors++;
      if ({ia.grant_o, ia.led_out, ia.active_o, ia.switch_count_o, ic.grant_o} !== 37'h0) begin
        miscompares++;
        $display("FAIL reset_idle cyc %0d: grant=%h led=%h active=%b count=%h c_grant=%h expected all zero",
                 i, ia.grant_o, ia.led_out, ia.active_o, ia.switch_count_o, ic.grant_o);
      end
    end
  endtask

  task automatic test_single_grant();
    pat[15:0] = 16'hA5A5;
    req = 4'b0001;
    tick();
    req = 4'b0000;
    for (int i = 1; i <= 9; i++) begin
      vectors++;
      if ({ia.grant_o, ia.led_out, ia.active_o} !== {4'b0001, 16'hA5A5, 1'b1}) begin
        miscompares++;
        $display("FAIL single_grant cyc %0d: grant=%h led=%h active=%b expected 1/a5a5/1",
                 i, ia.grant_o, ia.led_out, ia.active_o);
      end
      tick();
    end
    vectors++;
    if ({ia.grant_o, ia.led_out, ia.active_o, ia.switch_count_o} !== {4'b0, 16'h0, 1'b0, 16'd2}) begin
      miscompares++;
      $display("FAIL single_release: grant=%h led=%h active=%b count=%h expected 0/0000/0/0002",
               ia.grant_o, ia.led_out, ia.active_o, ia.switch_count_o);
    end
  endtask

  task automatic test_preempt();
    logic [3:0] ea, eb;
    drain();
    pat[15:0]  = 16'h1111;
    pat[47:32] = 16'hFF00;
    req = 4'b0001;
    tick(); tick(); tick();
    for (int e = 4; e <= 13; e++) begin
      req = (e <= 10) ? 4'b0101 : 4'b0000;
      tick();
      ea = (e <= 12) ? 4'b0100 : 4'b0000;
      eb = (e <= 9) ? 4'b0001 : 4'b0100;
      vectors++;
      if ({ia.grant_o, ia.led_out} !== {ea, (e <= 12) ? 16'hFF00 : 16'h0000}) begin
        miscompares++;
        $display("FAIL preempt_a edge %0d: grant=%h led=%h expected grant %h", e, ia.grant_o, ia.led_out, ea);
      end
      vectors++;
      if (ib.grant_o !== eb) begin
        miscompares++;
        $display("FAIL nopreempt_b edge %0d: grant=%h expected %h", e, ib.grant_o, eb);
      end
    end
  endtask

  task automatic test_handover();
    drain();
    pat[31:16] = 16'h2222;
    pat[63:48] = 16'h3333;
    req = 4'b1010;
    for (int i = 0; i < 10; i++) tick();
    vectors++;
    if ({ia.grant_o, ia.led_out} !== {4'b1000, 16'h3333}) begin
      miscompares++;
      $display("FAIL handover_own: grant=%h led=%h expected 8/3333", ia.grant_o, ia.led_out);
    end
    req = 4'b0010;
    tick();
    req = 4'b0000;
    for (int i = 1; i <= 9; i++) begin
      vectors++;
      if ({ia.grant_o, ia.led_out, ib.grant_o} !== {4'b0010, 16'h2222, 4'b0010}) begin
        miscompares++;
        $display("FAIL handover_hold cyc %0d: a_grant=%h led=%h b_grant=%h expected 2/2222/2",
                 i, ia.grant_o, ia.led_out, ib.grant_o);
      end
      tick();
    end
    vectors++;
    if (ia.grant_o !== 4'b0000) begin
      miscompares++;
      $display("FAIL handover_release: grant=%h expected 0", ia.grant_o);
    end
  endtask

  task automatic test_live_pattern();
    drain();
    pat[63:48] = 16'h0001;
    req = 4'b1111;
    tick();
    vectors++;
    if ({ia.grant_o, ia.led_out, ic.grant_o} !== {4'b1000, 16'h0001, 4'b1000}) begin
      miscompares++;
      $display("FAIL simultaneous: a_grant=%h led=%h c_grant=%h expected 8/0001/8", ia.grant_o, ia.led_out, ic.grant_o);
    end
    pat[63:48] = 16'h8000;
    vectors++;
    if (ia.led_out !== 16'h0001) begin
      miscompares++;
      $display("FAIL live_latency: led=%h expected 0001", ia.led_out);
    end
    tick();
    vectors++;
    if ({ia.grant_o, ia.led_out} !== {4'b1000, 16'h8000}) begin
      miscompares++;
      $display("FAIL live_pattern: grant=%h led=%h expected 8/8000", ia.grant_o, ia.led_out);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 0) pat = {$urandom(), $urandom()};
      tick();
      vectors++;
      if ({ia.grant_o, ia.led_out, ia.active_o, ia.switch_count_o} !==
          {m_grant[0], m_led[0], |m_grant[0], m_cnt[0]}) begin
        miscompares++;
        $display("FAIL random_a cyc %0d: grant=%h led=%h count=%h expected %h/%h/%h",
                 i, ia.grant_o, ia.led_out, ia.switch_count_o, m_grant[0], m_led[0], m_cnt[0]);
      end
      vectors++;
      if ({ib.grant_o, ib.led_out, ib.active_o, ib.switch_count_o} !==
          {m_grant[1], m_led[1], |m_grant[1], m_cnt[1]}) begin
        miscompares++;
        $display("FAIL random_b cyc %0d: grant=%h led=%h count=%h expected %h/%h/%h",
                 i, ib.grant_o, ib.led_out, ib.switch_count_o, m_grant[1], m_led[1], m_cnt[1]);
      end
      vectors++;
      if ({ic.grant_o, ic.led_out, ic.active_o, ic.switch_count_o} !==
          {m_grant[2], m_led[2], |m_grant[2], m_cnt[2]}) begin
        miscompares++;
        $display("FAIL random_c cyc %0d: grant=%h led=%h count=%h expected %h/%h/%h",
                 i, ic.grant_o, ic.led_out, ic.switch_count_o, m_grant[2], m_led[2], m_cnt[2]);
      end
    end
  endtask

  // With HOLD=1 this six-cycle pattern yields five ownership changes on instance c.
  task automatic test_saturation();
    logic [3:0] seq [6];
    seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100;
    seq[3] = 4'b1000; seq[4] = 4'b0000; seq[5] = 4'b0000;
    drain();
    for (int n = 0; n < 13110; n++) begin
      for (int j = 0; j < 6; j++) begin
        req = seq[j];
        tick();
      end
    end
    vectors++;
    if (ic.switch_count_o !== 16'hFFFF) begin
      miscompares++;
      $display("FAIL saturate: count=%h expected ffff", ic.switch_count_o);
    end
    for (int j = 0; j < 6; j++) begin
      req = seq[j];
      tick();
    end
    vectors++;
    if ({ic.switch_count_o, ia.switch_count_o, ib.switch_count_o} !== {16'hFFFF, m_cnt[0], m_cnt[1]}) begin
      miscompares++;
      $display("FAIL saturate_hold: c=%h a=%h b=%h expected ffff/%h/%h",
               ic.switch_count_o, ia.switch_count_o, ib.switch_count_o, m_cnt[0], m_cnt[1]);
    end
  endtask

  task automatic test_async_reset();
    drain();
    req = 4'b0001;
    tick(); tick();
    vectors++;
    if (ia.grant_o !== 4'b0001) begin
      miscompares++;
      $display("FAIL async_pre: grant=%h expected 1", ia.grant_o);
    end
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    vectors++;
    if ({ia.grant_o, ia.led_out, ia.active_o, ia.switch_count_o,
         ic.switch_count_o, ib.grant_o, ic.grant_o} !== 69'h0) begin
      miscompares++;
      $display("FAIL async_reset: a_grant=%h led=%h active=%b a_cnt=%h c_cnt=%h b_grant=%h c_grant=%h expected 0",
               ia.grant_o, ia.led_out, ia.active_o, ia.switch_count_o, ic.switch_count_o, ib.grant_o, ic.grant_o);
    end
    @(negedge clock);
    reset_n = 1'b1;
    req = 4'b0000;
    tick();
    vectors++;
    if ({ia.grant_o, ia.switch_count_o} !== {4'b0, 16'h0}) begin
      miscompares++;
      $display("FAIL async_after: grant=%h count=%h expected 0/0", ia.grant_o, ia.switch_count_o);
    end
    pat[47:32] = 16'h5A5A;
    req = 4'b0100;
    tick();
    vectors++;
    if ({ia.grant_o, ia.led_out, ia.switch_count_o} !== {4'b0100, 16'h5A5A, 16'd1}) begin
      miscompares++;
      $display("FAIL async_restart: grant=%h led=%h count=%h expected 4/5a5a/0001",
               ia.grant_o, ia.led_out, ia.switch_count_o);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset_n = 1'b0;
    req = 4'b0000;
    pat = 64'h0;
    model_reset();
    test_reset();
    test_single_grant();
    test_preempt();
    test_handover();
    test_live_pattern();
    test_random();
    test_saturation();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
